plab5_mcore_net_msg_to_mem_resp: RTL and testbench

PLAB5_MCORE_NET_MSG_TO_MEM_RESP -- requirements
Module: plab5_mcore_NetMsgToMemResp

---
 rtl/plab5_mcore_net_msg_to_mem_resp.sv | 79 +++++++
 tb/tb_plab5_mcore_net_msg_to_mem_resp.sv | 128 ++++++++++++
 2 files changed

// File: rtl/plab5_mcore_net_msg_to_mem_resp.sv
// plab5_mcore_net_msg_to_mem_resp: net response message to mem response adapter with 2-entry FIFO, misroute drop and domain squash
//   clk, reset (async active-low), cur_domain of the attached core
//   net_val/net_rdy/net_msg_control/net_msg_data : incoming net message {dest,src,opaque,domain,fail,type,mem_opaque,len}
//   mem_val/mem_rdy/mem_msg_control/mem_msg_data/mem_msg_fail/mem_msg_domain : response to core
//   drop_count, squash_count : saturating event counters
module plab5_mcore_net_msg_to_mem_resp #(
  parameter int p_net_dest          = 0,
  parameter int p_mem_opaque_nbits  = 8,
  parameter int p_mem_data_nbits    = 32,
  parameter int p_net_opaque_nbits  = 4,
  parameter int p_net_srcdest_nbits = 3,
  localparam int MC = 3 + p_mem_opaque_nbits + 2,
  localparam int NC = 2 * p_net_srcdest_nbits + p_net_opaque_nbits + 2 + MC
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cur_domain,
  input  logic                        net_val,
  output logic                        net_rdy,
  input  logic [NC-1:0]               net_msg_control,
  input  logic [p_mem_data_nbits-1:0] net_msg_data,
  output logic                        mem_val,
  input  logic                        mem_rdy,
  output logic [MC-1:0]               mem_msg_control,
  output logic [p_mem_data_nbits-1:0] mem_msg_data,
  output logic                        mem_msg_fail,
  output logic                        mem_msg_domain,
  output logic [7:0]                  drop_count,
  output logic [7:0]                  squash_count
);
  localparam int MD = p_mem_data_nbits;
  localparam int NS = p_net_srcdest_nbits;
  localparam int EW = MC + MD + 2;
  logic [EW-1:0] fifo [2];
  logic          wp, rp;
  logic [1:0]    count;
  logic [NS-1:0] dest;
  logic          msg_domain, msg_fail, hit, squash, in_fire, out_fire, wr;
  logic [EW-1:0] entry, head;
  always_comb begin
    dest       = net_msg_control[NC-1 -: NS];
    msg_domain = net_msg_control[MC+1];
    msg_fail   = net_msg_control[MC];
    hit        = dest == NS'(p_net_dest);
    squash     = msg_domain & ~cur_domain;
    net_rdy    = count < 2'd2;
    mem_val    = count != 2'd0;
    in_fire    = net_val & net_rdy;
    out_fire   = mem_val & mem_rdy;
    wr         = in_fire & hit;
    entry      = squash ? {net_msg_control[MC-1:0], {MD{1'b0}}, 1'b1, cur_domain}
                        : {net_msg_control[MC-1:0], net_msg_data, msg_fail, msg_domain};
    head       = fifo[rp];
  end
  assign mem_msg_control = head[EW-1 -: MC];
  assign mem_msg_data    = head[MD+1:2];
  assign mem_msg_fail    = head[1];
  assign mem_msg_domain  = head[0];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo[0]      <= '0;
      fifo[1]      <= '0;
      wp           <= 1'b0;
      rp           <= 1'b0;
      count        <= 2'd0;
      drop_count   <= 8'd0;
      squash_count <= 8'd0;
    end else begin
      if (wr) begin
        fifo[wp] <= entry;
        wp       <= ~wp;
      end
      if (out_fire) rp <= ~rp;
      count <= count + {1'b0, wr} - {1'b0, out_fire};
      if (in_fire && !hit && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
      if (wr && squash && squash_count != 8'hff) squash_count <= squash_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_plab5_mcore_net_msg_to_mem_resp.sv
// tb_plab5_mcore_net_msg_to_mem_resp: randomized and directed checks against a queue-based reference model
module tb_plab5_mcore_net_msg_to_mem_resp;
  logic        clk = 0, reset = 0, cur_domain = 0, net_val = 0, mem_rdy = 0;
  logic        net_rdy, mem_val, mem_msg_fail, mem_msg_domain;
  logic [24:0] net_msg_control = '0;
  logic [31:0] net_msg_data = '0, mem_msg_data;
  logic [12:0] mem_msg_control;
  logic [7:0]  drop_count, squash_count;
  typedef struct packed {logic [12:0] c; logic [31:0] d; logic f; logic m;} ent_t;
  ent_t q[$];
  int drop = 0, squash = 0, n_cmp = 0, n_bad = 0;
  logic acc;
  plab5_mcore_net_msg_to_mem_resp dut (
    .clk(clk), .reset(reset), .cur_domain(cur_domain),
    .net_val(net_val), .net_rdy(net_rdy),
    .net_msg_control(net_msg_control), .net_msg_data(net_msg_data),
    .mem_val(mem_val), .mem_rdy(mem_rdy),
    .mem_msg_control(mem_msg_control), .mem_msg_data(mem_msg_data),
    .mem_msg_fail(mem_msg_fail), .mem_msg_domain(mem_msg_domain),
    .drop_count(drop_count), .squash_count(squash_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [24:0] mk(input int dest, input logic dom, input logic f,
                                      input logic [2:0] t, input logic [7:0] mo, input logic [1:0] len);
    logic [2:0] src = 3'($urandom);
    logic [3:0] opq = 4'($urandom);
    return {3'(dest), src, opq, dom, f, t, mo, len};
  endfunction
  task automatic check_out();
    chk("net_rdy", net_rdy, q.size() < 2);
    chk("mem_val", mem_val, q.size() != 0);
    chk("drop_count", drop_count, drop);
    chk("squash_count", squash_count, squash);
    if (q.size() != 0) begin
      chk("ctrl", mem_msg_control, q[0].c);
      chk("data", mem_msg_data, q[0].d);
      chk("fail", mem_msg_fail, q[0].f);
      chk("domain", mem_msg_domain, q[0].m);
    end
  endtask
  // Called at a falling edge: check outputs, drive one cycle of inputs, advance the model, wait a cycle.
  task automatic cyc(input logic v, input logic [24:0] ctl, input logic [31:0] d,
                     input logic cd, input logic rdy, output logic accepted);
    logic in_f, out_f;
    check_out();
    net_val = v; net_msg_control = ctl; net_msg_data = d; cur_domain = cd; mem_rdy = rdy;
    in_f  = v && q.size() < 2;
    out_f = rdy && q.size() != 0;
    accepted = in_f;
    if (out_f) void'(q.pop_front());
    if (in_f) begin
      if (ctl[24:22] != 3'd0) drop = drop < 255 ? drop + 1 : 255;
      else if (ctl[14] && !cd) begin
        q.push_back('{c: ctl[12:0], d: 32'd0, f: 1'b1, m: cd});
        squash = squash < 255 ? squash + 1 : 255;
      end else q.push_back('{c: ctl[12:0], d: d, f: ctl[13], m: ctl[14]});
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, cur_domain, rdy, acc);
  endtask
  initial begin
    #3;
    chk("rst_mem_val", mem_val, 0);
    chk("rst_net_rdy", net_rdy, 1);
    chk("rst_data", mem_msg_data, 0);
    @(negedge clk); @(negedge clk);
    reset = 1;
    @(negedge clk);
    cyc(1, mk(0, 0, 0, 0, 8'h05, 0), 32'hDEADBEEF, 0, 1, acc);
    chk("pass_val", mem_val, 1);
    chk("pass_ctrl", mem_msg_control, {3'd0, 8'h05, 2'd0});
    chk("pass_data", mem_msg_data, 32'hDEADBEEF);
    idle(2, 1);
    for (int i = 0; i < 3; i++) cyc(1, mk(0, 0, 0, 3'(i), 8'(i), 0), 32'hA000 + i, 0, 0, acc);
    chk("bp_third_rejected", acc, 0);
    do cyc(1, mk(0, 0, 0, 2, 8'd2, 0), 32'hA002, 0, 1, acc); while (!acc);
    idle(3, 1);
    for (int i = 0; i < 300; i++) cyc(1, mk(2, 0, 0, 0, 0, 0), 32'h1, 0, 1, acc);
    chk("drop_sat", drop_count, 255);
    cyc(1, mk(0, 1, 0, 1, 8'h33, 1), 32'h12345678, 0, 1, acc);
    chk("squash_data", mem_msg_data, 0);
    chk("squash_fail", mem_msg_fail, 1);
    cyc(1, mk(0, 1, 0, 1, 8'h33, 1), 32'h12345678, 1, 1, acc);
    chk("nosq_data", mem_msg_data, 32'h12345678);
    chk("nosq_domain", mem_msg_domain, 1);
    idle(2, 1);
    cyc(1, mk(0, 0, 0, 0, 8'h70, 0), 32'h70, 0, 0, acc);
    for (int i = 0; i < 10; i++) cyc(1, mk(0, 0, 1, 3'(i), 8'(i), 2'(i)), $urandom, 0, 1, acc);
    idle(3, 1);
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 3) != 0,
          mk($urandom_range(0, 5) == 0 ? 3 : 0, 1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom), 2'($urandom)),
          $urandom, 1'($urandom), $urandom_range(0, 2) != 0, acc);
    idle(1, 0);
    cyc(1, mk(0, 0, 0, 0, 8'h11, 0), 32'h11, 0, 0, acc);
    cyc(1, mk(0, 0, 0, 0, 8'h22, 0), 32'h22, 0, 0, acc);
    check_out();
    chk("pre_rst_full", net_rdy, 0);
    #2 reset = 0;
    #1;
    chk("arst_mem_val", mem_val, 0);
    chk("arst_net_rdy", net_rdy, 1);
    chk("arst_drop", drop_count, 0);
    chk("arst_squash", squash_count, 0);
    chk("arst_data", mem_msg_data, 0);
    q.delete(); drop = 0; squash = 0;
    net_val = 1; mem_rdy = 1;
    @(negedge clk);
    chk("rst_hold_val", mem_val, 0);
    reset = 1;
    net_val = 0;
    #1;
    cyc(1, mk(0, 0, 0, 5, 8'h99, 3), 32'hCAFEF00D, 0, 1, acc);
    chk("post_rst_data", mem_msg_data, 32'hCAFEF00D);
    idle(3, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
